// File: rtl/sum_display_pkg.sv
// Shared definitions for the sum_display block: FSM state type, active-low
// seven-segment patterns for decimal digits, the blank pattern and the
// default refresh divider.
package sum_display_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int unsigned REFRESH_DIV_DEFAULT = 50000;
  localparam int unsigned CNT_W               = 20;

  // Segment order g,f,e,d,c,b,a; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sum_display_if.sv
// Handshake bundle between the 4-bit adder stage and sum_display.
//   sum_in/carry_in : adder result (carry has weight 16)
//   sum_valid       : one-cycle capture strobe
//   sum_ready       : display block idle and able to capture
//   conv_done       : one-cycle pulse when new digits are shown
interface sum_display_if;
  logic [3:0] sum_in;
  logic       carry_in;
  logic       sum_valid;
  logic       sum_ready;
  logic       conv_done;

  modport master (
    output sum_in, carry_in, sum_valid,
    input  sum_ready, conv_done
  );

  modport slave (
    input  sum_in, carry_in, sum_valid,
    output sum_ready, conv_done
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
//   i_digit : 4-bit digit code
//   o_seg   : segments g..a, active-low; non-decimal codes are blanked
module seg7_decoder
  import sum_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_display.sv
// Captures a 5-bit adder result (0..31), converts it to two decimal digits
// by repeated subtraction of 10, and drives a two-digit multiplexed
// active-low seven-segment display.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of sum_display_if (capture handshake)
//   seg        : segments g..a, active-low
//   an         : digit enables, active-low; an[0]=units, an[1]=tens
module sum_display
  import sum_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  sum_display_if.slave    bus,
  output logic [6:0]      seg,
  output logic [1:0]      an
);

  state_t           r_state, w_state_nxt;
  logic [4:0]       r_rem, w_rem_nxt;
  logic [3:0]       r_tens_acc, w_tens_acc_nxt;
  logic [3:0]       r_disp_tens, w_disp_tens_nxt;
  logic [3:0]       r_disp_units, w_disp_units_nxt;
  logic             r_conv_done, w_conv_done_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_digit_sel;

  logic [4:0] w_value;
  logic [3:0] w_digit;
  logic [6:0] w_seg_dec;
  logic       w_cnt_wrap;

  assign w_value = {bus.carry_in, bus.sum_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rem        <= '0;
      r_tens_acc   <= '0;
      r_disp_tens  <= '0;
      r_disp_units <= '0;
      r_conv_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rem        <= w_rem_nxt;
      r_tens_acc   <= w_tens_acc_nxt;
      r_disp_tens  <= w_disp_tens_nxt;
      r_disp_units <= w_disp_units_nxt;
      r_conv_done  <= w_conv_done_nxt;
    end
  end

  // Display registers are written only on the final conversion step, so
  // both digits switch together.
  always_comb begin
    w_state_nxt      = r_state;
    w_rem_nxt        = r_rem;
    w_tens_acc_nxt   = r_tens_acc;
    w_disp_tens_nxt  = r_disp_tens;
    w_disp_units_nxt = r_disp_units;
    w_conv_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sum_valid) begin
          w_rem_nxt      = w_value;
          w_tens_acc_nxt = '0;
          w_state_nxt    = CONVERT;
        end
      end
      CONVERT: begin
        if (r_rem >= 5'd10) begin
          w_rem_nxt      = r_rem - 5'd10;
          w_tens_acc_nxt = r_tens_acc + 4'd1;
        end else begin
          w_disp_tens_nxt  = r_tens_acc;
          w_disp_units_nxt = r_rem[3:0];
          w_conv_done_nxt  = 1'b1;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.sum_ready = (r_state == IDLE);
  assign bus.conv_done = r_conv_done;

  // Free-running refresh counter, independent of the conversion FSM.
  assign w_cnt_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_digit_sel <= 1'b0;
    end else if (w_cnt_wrap) begin
      r_cnt       <= '0;
      r_digit_sel <= ~r_digit_sel;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_digit = r_digit_sel ? r_disp_tens : r_disp_units;

  seg7_decoder u_seg7_decoder (
    .i_digit (w_digit),
    .o_seg   (w_seg_dec)
  );

  // Tens digit blanked when zero; the enable still rotates normally.
  always_comb begin
    seg = w_seg_dec;
    an  = 2'b10;
    if (r_digit_sel) begin
      an = 2'b01;
      if (r_disp_tens == 4'd0) seg = SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_sum_display.sv
module tb_sum_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [1:0] an;

  sum_display_if bus_if ();

  sum_display #(.REFRESH_DIV(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: displayed digits, pending digits, edges left
  // until the pending digits appear, edges since reset release.
  int m_tens, m_units, m_pt, m_pu, m_left, m_k;
  bit m_done;

  logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit         sel;
    logic [6:0] exp_seg;
    sel = ((m_k / 4) % 2) == 1;
    if (sel) exp_seg = (m_tens == 0) ? 7'h7F : tbl[m_tens];
    else     exp_seg = tbl[m_units];
    check("sum_ready", 32'(bus_if.sum_ready), 32'(m_left == 0));
    check("conv_done", 32'(bus_if.conv_done), 32'(m_done));
    check("an", 32'(an), sel ? 32'h1 : 32'h2);
    check("seg", 32'(seg), 32'(exp_seg));
  endtask

  task automatic model_reset();
    m_tens = 0; m_units = 0; m_pt = 0; m_pu = 0;
    m_left = 0; m_k = 0; m_done = 1'b0;
  endtask

  // Drive inputs, take one rising edge, advance the model, check at negedge.
  task automatic step(input logic valid, input logic [4:0] v);
    bus_if.sum_valid = valid;
    bus_if.sum_in    = v[3:0];
    bus_if.carry_in  = v[4];
    @(posedge clk);
    m_k++;
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_tens  = m_pt;
        m_units = m_pu;
        m_done  = 1'b1;
      end
    end else if (valid) begin
      m_pt   = int'(v) / 10;
      m_pu   = int'(v) % 10;
      m_left = int'(v) / 10 + 1;
    end
    @(negedge clk);
    bus_if.sum_valid = 1'b0;
    check_outputs();
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'h2);
    check("rst_seg", 32'(seg), 32'h40);
    check("rst_ready", 32'(bus_if.sum_ready), 32'h1);
    check("rst_done", 32'(bus_if.conv_done), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_and_time(input logic [4:0] v);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    step(1'b1, v);
    while (!seen && n < 8) begin
      step(1'b0, 5'd0);
      n++;
      if (bus_if.conv_done) seen = 1'b1;
    end
    check("latency", 32'(n), 32'(int'(v) / 10 + 1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0);
  endtask

  initial begin
    int low;
    rst_n = 1'b0;
    bus_if.sum_valid = 1'b0;
    bus_if.sum_in    = '0;
    bus_if.carry_in  = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    check("init_seg", 32'(seg), 32'h40);
    rst_n = 1'b1;

    // Free-run: enable rotates every 4 cycles
    idle_cycles(16);

    // v=30: 4-edge latency, tens 3
    send_and_time(5'd30);
    idle_cycles(8);

    // v=7: 1-edge latency, tens blanked
    send_and_time(5'd7);
    idle_cycles(8);

    // v=25 then ignored strobes of v=9
    low = 0;
    step(1'b1, 5'd25); if (!bus_if.sum_ready) low++;
    step(1'b1, 5'd9);  if (!bus_if.sum_ready) low++;
    step(1'b1, 5'd9);  if (!bus_if.sum_ready) low++;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5'd0);
      if (!bus_if.sum_ready) low++;
    end
    check("ready_low", 32'(low), 32'd3);
    check("tens25", 32'(m_tens), 32'd2);
    idle_cycles(8);

    // Reset during conversion of v=31, then v=10
    step(1'b1, 5'd31);
    step(1'b0, 5'd0);
    mid_reset();
    idle_cycles(3);
    send_and_time(5'd10);
    idle_cycles(8);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic       vld;
      logic [4:0] val;
      vld = ($urandom_range(0, 2) == 0);
      val = 5'($urandom_range(0, 31));
      step(vld, val);
    end
    idle_cycles(6);

    mid_reset();
    idle_cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_display.md
SUM_DISPLAY -- requirements
Module: sum_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clock cycles per digit refresh slot; legal range 2..2^20.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sum_in  input  4  sum bits o3..o0 from the 4-bit adder stage, sum_in[0]=o0.
REQ-005 carry_in  input  1  carry out of the 4-bit adder stage, weight 16.
REQ-006 sum_valid  input  1  one-cycle strobe, sum_in/carry_in stable and to be captured.
REQ-007 sum_ready  output  1  high when the block will accept sum_valid.
REQ-008 conv_done  output  1  one-cycle pulse when new digits are loaded into the display.
REQ-009 seg  output  7  segment drive, active-low, seg[6:0]=g,f,e,d,c,b,a.
REQ-010 an  output  2  digit enables, active-low, an[0]=units, an[1]=tens.

Function
REQ-011 Captured value SHALL be v = 16*carry_in + sum_in, 5-bit, range 0..31.
REQ-012 FSM states SHALL be IDLE and CONVERT only.
REQ-013 sum_ready SHALL be 1 exactly when state is IDLE.
REQ-014 IDLE with sum_valid=1 at an edge: rem<=v, tens_acc<=0, state<=CONVERT.
REQ-015 sum_valid while in CONVERT SHALL be ignored (no capture, no buffering).
REQ-016 CONVERT edge with rem>=10: rem<=rem-10, tens_acc<=tens_acc+1, stay CONVERT.
REQ-017 CONVERT edge with rem<10: disp_tens<=tens_acc, disp_units<=rem, conv_done<=1 for one cycle, state<=IDLE.
REQ-018 Latency: capture at edge N; digits updated and conv_done high after edge N+floor(v/10)+1; max 4 edges (v=30,31).
REQ-019 Displayed digits SHALL change atomically; no intermediate value visible on seg.
REQ-020 Refresh counter SHALL count 0..REFRESH_DIV-1 continuously, independent of FSM; on wrap to 0 digit_sel toggles.
REQ-021 digit_sel=0: an=2'b10, seg=decode(disp_units); digit_sel=1: an=2'b01, seg=decode(disp_tens).
REQ-022 Leading-zero blanking: digit_sel=1 and disp_tens=0 SHALL give seg=7'h7F, an unchanged.
REQ-023 Decode (hex, active-low): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10; other codes 7F.
REQ-024 an SHALL never be 2'b00; exactly one digit enabled every cycle.
REQ-025 seg/an SHALL be combinational from registered digit_sel, disp_tens, disp_units only.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, sum_ready=1, conv_done=0, rem=0, tens_acc=0, disp_tens=0, disp_units=0, counter=0, digit_sel=0.
REQ-027 Resulting reset outputs: an=2'b10, seg=7'h40 (units shows 0).
REQ-028 Reset during CONVERT SHALL abandon conversion; display keeps reset values, no conv_done.
REQ-029 Deassertion SHALL take effect at the first rising edge after rst_n goes high; counter restarts from 0.

Structure
REQ-030 Package sum_display_pkg SHALL hold: FSM state enum, segment decode constants (REQ-023), blank pattern 7'h7F, REFRESH_DIV default.
REQ-031 One sub-module seg7_decoder (4-bit digit in, 7-bit active-low segments out, combinational), instantiated once after the digit mux.
REQ-032 Counter width SHALL be 20 bits; no other arithmetic wider than 5 bits.

Verification
REQ-033 Reset: rst_n low mid-run -> an=2'b10, seg=7'h40, sum_ready=1 same cycle, no clock needed.
REQ-034 sum_in=4'b1110, carry_in=1 (v=30), REFRESH_DIV=4 -> conv_done after 4 edges; units slot seg=7'h40, tens slot seg=7'h30.
REQ-035 sum_in=4'b0111, carry_in=0 (v=7) -> conv_done after 1 edge; units seg=7'h78, tens slot seg=7'h7F blanked.
REQ-036 v=25 captured, sum_valid=1 with v=9 on next two edges -> second capture ignored, display tens=2 (7'h24), units=5 (7'h12), sum_ready low exactly 3 cycles.
REQ-037 REFRESH_DIV=4, free-run 16 cycles -> an toggles every 4 cycles, pattern 10,01,10,01; never 00 or 11.
REQ-038 rst_n pulsed during CONVERT of v=31 -> no conv_done, display stays 0, next capture of v=10 shows tens 1 (7'h79), units 0 (7'h40).
